// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: up/down BCD counter with multiplexed seven-segment scan.
module bcd_scan_counter #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  show_ext,
    input  logic [3:0]            ext_nibble,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic INV = COMMON_ANODE != 0;
    localparam logic [16*7-1:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    logic [DW-1:0]       div;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] inc_val, dec_val, ld_val;
    logic                all_nines, all_zeros;
    logic [3:0]          d, nib;
    logic                blank;
    logic [6:0]          seg_val;
    always_comb begin
        inc_val   = '0;
        dec_val   = '0;
        ld_val    = '0;
        all_nines = 1'b1;
        all_zeros = 1'b1;
        d         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            inc_val[4*i +: 4] = all_nines ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
            dec_val[4*i +: 4] = all_zeros ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
            all_nines = all_nines && d == 4'd9;
            all_zeros = all_zeros && d == 4'd0;
            ld_val[4*i +: 4] = load_val[4*i +: 4] > 4'd9 ? 4'd9 : load_val[4*i +: 4];
        end
    end
    // A digit is a leading zero when it and everything above it is zero.
    assign nib     = show_ext ? ext_nibble : count[4*idx +: 4];
    assign blank   = blank_lz && !show_ext && idx != '0 && (count >> (4*idx)) == '0;
    assign seg_val = blank ? 7'h00 : SEG_LUT[7*nib +: 7];
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            wrap    <= 1'b0;
            div     <= '0;
            idx     <= '0;
            seg     <= {7{INV}};
            dp      <= INV;
            dig_sel <= {DIGITS{INV}};
        end else begin
            count   <= clr ? '0 : load ? ld_val : en ? (up ? inc_val : dec_val) : count;
            wrap    <= !clr && !load && en && (up ? all_nines : all_zeros);
            div     <= div == DW'(SCAN_DIV - 1) ? '0 : div + 1'b1;
            idx     <= div != DW'(SCAN_DIV - 1) ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            seg     <= {7{INV}} ^ seg_val;
            dp      <= INV ^ (idx == '0 && !en);
            dig_sel <= {DIGITS{INV}} ^ (DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed checks of counting, wrap, load clamp and display scan.
module tb_bcd_scan_counter;
    logic       clk = 1'b0;
    logic       rst, en, up, clr, load, show_ext, blank_lz;
    logic [7:0] load_val;
    logic [3:0] ext_nibble;
    logic [7:0] count;
    logic       wrap, dp;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    int checks = 0;
    int errors = 0;

    bcd_scan_counter #(.DIGITS(2), .SCAN_DIV(4), .COMMON_ANODE(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .show_ext(show_ext), .ext_nibble(ext_nibble),
        .blank_lz(blank_lz), .count(count), .wrap(wrap), .seg(seg), .dp(dp),
        .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_digit(input logic [1:0] want);
        int n = 0;
        while (dig_sel !== want && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (dig_sel !== want) begin
            errors++;
            $display("FAIL wait_digit: dig_sel=%b required %b", dig_sel, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count=%h wrap=%b required 00 0", count, wrap);
        end
        checks++;
        if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 2'b00) begin
            errors++;
            $display("FAIL reset_display: seg=%h dp=%b dig_sel=%b required 00 0 00", seg, dp, dig_sel);
        end
        rst = 1'b0;
        step();
        checks++;
        if (seg !== 7'h3F || dig_sel !== 2'b01 || dp !== 1'b1) begin
            errors++;
            $display("FAIL first_edge: seg=%h dig_sel=%b dp=%b required 3f 01 1", seg, dig_sel, dp);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            exp = ((k / 4) % 2) != 0 ? 2'b10 : 2'b01;
            checks++;
            if (dig_sel !== exp) begin
                errors++;
                $display("FAIL scan[%0d]: dig_sel=%b required %b", k, dig_sel, exp);
            end
        end
    endtask

    task automatic test_up_wrap();
        load_val = 8'h99;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (count !== 8'h99 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_99: count=%h wrap=%b required 99 0", count, wrap);
        end
        en = 1'b1;
        up = 1'b1;
        step();
        en = 1'b0;
        checks++;
        if (count !== 8'h00 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap: count=%h wrap=%b required 00 1", count, wrap);
        end
        step();
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_pulse: count=%h wrap=%b required 00 0", count, wrap);
        end
    endtask

    task automatic test_down_wrap();
        en = 1'b1;
        up = 1'b0;
        step();
        checks++;
        if (count !== 8'h99 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: count=%h wrap=%b required 99 1", count, wrap);
        end
        step();
        en = 1'b0;
        checks++;
        if (count !== 8'h98 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_step: count=%h wrap=%b required 98 0", count, wrap);
        end
    endtask

    task automatic test_carry();
        load_val = 8'h19;
        load = 1'b1;
        step();
        load = 1'b0;
        en = 1'b1;
        up = 1'b1;
        step();
        checks++;
        if (count !== 8'h20 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL carry: count=%h wrap=%b required 20 0", count, wrap);
        end
        up = 1'b0;
        step();
        en = 1'b0;
        checks++;
        if (count !== 8'h19) begin
            errors++;
            $display("FAIL borrow: count=%h required 19", count);
        end
        step();
        checks++;
        if (count !== 8'h19) begin
            errors++;
            $display("FAIL hold: count=%h required 19", count);
        end
    endtask

    task automatic test_load_clr();
        load_val = 8'hA3;
        load = 1'b1;
        step();
        checks++;
        if (count !== 8'h93) begin
            errors++;
            $display("FAIL load_clamp: count=%h required 93", count);
        end
        load_val = 8'h4F;
        step();
        checks++;
        if (count !== 8'h49) begin
            errors++;
            $display("FAIL load_clamp_lo: count=%h required 49", count);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_load: count=%h wrap=%b required 00 0", count, wrap);
        end
        load_val = 8'h42;
        en = 1'b1;
        up = 1'b1;
        step();
        load = 1'b0;
        en = 1'b0;
        checks++;
        if (count !== 8'h42) begin
            errors++;
            $display("FAIL load_over_en: count=%h required 42", count);
        end
    endtask

    task automatic test_display();
        load_val = 8'h05;
        load = 1'b1;
        step();
        load = 1'b0;
        blank_lz = 1'b1;
        step();
        wait_digit(2'b10);
        checks++;
        if (seg !== 7'h00 || dp !== 1'b0) begin
            errors++;
            $display("FAIL blank_d1: seg=%h dp=%b required 00 0", seg, dp);
        end
        wait_digit(2'b01);
        checks++;
        if (seg !== 7'h6D || dp !== 1'b1) begin
            errors++;
            $display("FAIL show_d0: seg=%h dp=%b required 6d 1", seg, dp);
        end
        show_ext = 1'b1;
        ext_nibble = 4'hE;
        step();
        wait_digit(2'b10);
        checks++;
        if (seg !== 7'h79) begin
            errors++;
            $display("FAIL ext_d1: seg=%h required 79", seg);
        end
        wait_digit(2'b01);
        checks++;
        if (seg !== 7'h79) begin
            errors++;
            $display("FAIL ext_d0: seg=%h required 79", seg);
        end
        show_ext = 1'b0;
        blank_lz = 1'b0;
        step();
        wait_digit(2'b10);
        checks++;
        if (seg !== 7'h3F) begin
            errors++;
            $display("FAIL noblank_d1: seg=%h required 3f", seg);
        end
    endtask

    task automatic test_reset_mid();
        load_val = 8'h47;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (count !== 8'h47) begin
            errors++;
            $display("FAIL load_47: count=%h required 47", count);
        end
        en = 1'b1;
        up = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if (count !== 8'h00 || dig_sel !== 2'b00 || seg !== 7'h00 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%h dig_sel=%b seg=%h wrap=%b required 00 00 00 0",
                     count, dig_sel, seg, wrap);
        end
        rst = 1'b0;
        step();
        checks++;
        if (dig_sel !== 2'b01 || dp !== 1'b0 || count !== 8'h01) begin
            errors++;
            $display("FAIL run_after_rst: dig_sel=%b dp=%b count=%h required 01 0 01", dig_sel, dp, count);
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        show_ext = 1'b0; blank_lz = 1'b0; load_val = '0; ext_nibble = '0;
        test_reset();
        test_scan();
        test_up_wrap();
        test_down_wrap();
        test_carry();
        test_load_clr();
        test_display();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
